// File: rtl/instruction_issuer.sv
// Byte-to-word instruction assembler with FIFO buffering and a gap-paced
// one-cycle issue strobe toward the pixel generator's instruction port.
module instruction_issuer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int ISSUE_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  input  logic        i_hold,
  input  logic        i_clear_flags,
  output logic [31:0] o_instruction,
  output logic        o_instruction_ready,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [1:0]    k;
  logic [23:0]   part_p0;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic [31:0]   word_p1;
  logic          vld_p1;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count;
  logic          empty, full, push, ovf_set;

  state_t        state, state_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic          can_issue, issue_go;

  // ---- stage p0: byte assembly and partial-word timeout ----
  // A byte arriving on the timeout cycle takes priority, so tmo_hit needs !i_rx_valid.
  assign tmo_hit = !i_rx_valid && (k != 2'd0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      k       <= 2'd0;
      tmo_cnt <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= i_rx_valid && (k == 2'd3) && (part_p0[7:0] != 8'h00);
      if (i_rx_valid) begin
        k       <= k + 2'd1;
        tmo_cnt <= '0;
      end else if (tmo_hit) begin
        k       <= 2'd0;
        tmo_cnt <= '0;
      end else if (k != 2'd0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rx_valid) begin
      case (k)
        2'd0:    part_p0[7:0]   <= i_rx_byte;
        2'd1:    part_p0[15:8]  <= i_rx_byte;
        2'd2:    part_p0[23:16] <= i_rx_byte;
        default: part_p0        <= part_p0;
      endcase
      word_p1 <= {i_rx_byte, part_p0};
    end
  end

  // ---- stage p1: FIFO push / pop ----
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push    = vld_p1 && (!full || issue_go);
  assign ovf_set = vld_p1 && full && !issue_go;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word_p1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_overflow    <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (issue_go) rd_ptr <= rd_ptr + (AW + 1)'(1);
      o_overflow    <= (o_overflow && !i_clear_flags) || ovf_set;
      o_frame_error <= (o_frame_error && !i_clear_flags) || tmo_hit;
    end
  end

  // ---- stage p2: issue FSM and registered strobe ----
  assign can_issue = !empty && !i_hold;

  always_comb begin
    state_nx = state;
    gap_nx   = gap_cnt;
    issue_go = 1'b0;
    case (state)
      IDLE: begin
        if (can_issue && (gap_cnt == '0)) begin
          issue_go = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (ISSUE_GAP == 0) begin
          if (can_issue) issue_go = 1'b1;
          else           state_nx = IDLE;
        end else begin
          state_nx = GAP;
          gap_nx   = GW'(ISSUE_GAP);
        end
      end
      GAP: begin
        gap_nx = gap_cnt - GW'(1);
        // The cycle the counter reaches 0 doubles as the IDLE decision.
        if (gap_cnt <= GW'(1)) begin
          gap_nx = '0;
          if (can_issue) begin
            issue_go = 1'b1;
            state_nx = ISSUE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state               <= IDLE;
      gap_cnt             <= '0;
      o_instruction_ready <= 1'b0;
      o_instruction       <= '0;
    end else begin
      state               <= state_nx;
      gap_cnt             <= gap_nx;
      o_instruction_ready <= issue_go;
      o_instruction       <= issue_go ? mem[rd_ptr[AW-1:0]] : '0;
    end
  end

  assign o_busy = !empty || (k != 2'd0) || vld_p1 || (state != IDLE);

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench for instruction_issuer: latency, pacing, NOP drop, timeout,
// overflow and reset behaviour with hand-computed expectations.
module tb_instruction_issuer;
  localparam int FIFO_DEPTH     = 8;
  localparam int ISSUE_GAP      = 2;
  localparam int TIMEOUT_CYCLES = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        hold;
  logic        clr;
  logic [31:0] instr;
  logic        ready;
  logic        busy;
  logic        ovf;
  logic        ferr;

  int          n_vec  = 0;
  int          n_err  = 0;
  int          nz_err = 0;
  int          cyc    = 0;
  int          t_last;
  logic [31:0] q_val[$];
  int          q_cyc[$];

  instruction_issuer #(
    .FIFO_DEPTH(FIFO_DEPTH), .ISSUE_GAP(ISSUE_GAP), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .i_hold(hold), .i_clear_flags(clr), .o_instruction(instr),
    .o_instruction_ready(ready), .o_busy(busy), .o_overflow(ovf), .o_frame_error(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log; o_instruction must be zero on every non-strobe cycle.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      q_val.push_back(instr);
      q_cyc.push_back(cyc);
    end else if (instr !== 32'h0) begin
      nz_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] val_at(input int i);
    return (q_val.size() > i) ? q_val[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int cyc_at(input int i);
    return (q_cyc.size() > i) ? q_cyc[i] : -1000;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_val.delete();
    q_cyc.delete();
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; hold = 1'b0; clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_busy",  {31'b0, busy},  32'h0);
    chk("rst_ovf",   {31'b0, ovf},   32'h0);
    chk("rst_ferr",  {31'b0, ferr},  32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // single word: strobe two cycles after the 4th byte
    clear_log();
    send_word(32'h0012_3407);
    t_last = cyc;
    idle(6);
    chk("t1_count", q_val.size(), 1);
    chk("t1_val",   val_at(0), 32'h0012_3407);
    chk("t1_lat",   cyc_at(0), t_last + 2);
    chk("t1_busy",  {31'b0, busy}, 32'h0);

    // three queued words released together: one strobe every 3 cycles
    clear_log();
    hold = 1'b1;
    send_word(32'h000F_FF01);
    send_word(32'h0000_0002);
    send_word(32'h0000_0005);
    idle(2);
    chk("t2_held", q_val.size(), 0);
    chk("t2_busy", {31'b0, busy}, 32'h1);
    hold = 1'b0;
    idle(14);
    chk("t2_count", q_val.size(), 3);
    chk("t2_val0",  val_at(0), 32'h000F_FF01);
    chk("t2_val1",  val_at(1), 32'h0000_0002);
    chk("t2_val2",  val_at(2), 32'h0000_0005);
    chk("t2_gap01", cyc_at(1) - cyc_at(0), 3);
    chk("t2_gap12", cyc_at(2) - cyc_at(1), 3);

    // NOP opcode dropped, following word unaffected
    clear_log();
    send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(6);
    chk("t3_nop_cnt",  q_val.size(), 0);
    chk("t3_nop_ovf",  {31'b0, ovf},  32'h0);
    chk("t3_nop_ferr", {31'b0, ferr}, 32'h0);
    chk("t3_nop_busy", {31'b0, busy}, 32'h0);
    send_word(32'h0000_0006);
    t_last = cyc;
    idle(4);
    chk("t3_count", q_val.size(), 1);
    chk("t3_val",   val_at(0), 32'h0000_0006);
    chk("t3_lat",   cyc_at(0), t_last + 2);

    // byte landing on the exact timeout cycle is accepted
    clear_log();
    send_byte(8'h0B); send_byte(8'h01); send_byte(8'h02);
    idle(TIMEOUT_CYCLES - 1);
    send_byte(8'h03);
    idle(4);
    chk("t4_edge_ferr", {31'b0, ferr}, 32'h0);
    chk("t4_edge_cnt",  q_val.size(), 1);
    chk("t4_edge_val",  val_at(0), 32'h0302_010B);

    // partial word times out, next word stays aligned
    clear_log();
    send_byte(8'h11); send_byte(8'h22);
    idle(TIMEOUT_CYCLES - 1);
    chk("t4_pre_ferr", {31'b0, ferr}, 32'h0);
    idle(1);
    chk("t4_ferr", {31'b0, ferr}, 32'h1);
    chk("t4_busy", {31'b0, busy}, 32'h0);
    send_word(32'h0000_0003);
    idle(4);
    chk("t4_count", q_val.size(), 1);
    chk("t4_val",   val_at(0), 32'h0000_0003);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("t4_clr", {31'b0, ferr}, 32'h0);

    // overflow: FIFO_DEPTH+1 words under hold
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w = {8'hC3, 8'h5A, 8'(i), 8'(8'h20 + i)};
      send_word(w);
    end
    idle(2);
    chk("t5_full_ovf", {31'b0, ovf}, 32'h0);
    w = {8'hC3, 8'h5A, 8'(FIFO_DEPTH), 8'(8'h20 + FIFO_DEPTH)};
    send_word(w);
    idle(2);
    chk("t5_ovf",  {31'b0, ovf}, 32'h1);
    chk("t5_held", q_val.size(), 0);
    hold = 1'b0;
    idle(3 * FIFO_DEPTH + 8);
    chk("t5_count", q_val.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w = {8'hC3, 8'h5A, 8'(i), 8'(8'h20 + i)};
      chk($sformatf("t5_val%0d", i), val_at(i), w);
      if (i > 0) chk($sformatf("t5_gap%0d", i), cyc_at(i) - cyc_at(i - 1), 3);
    end
    chk("t5_ovf_sticky", {31'b0, ovf}, 32'h1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("t5_clr", {31'b0, ovf}, 32'h0);

    // reset mid-word
    clear_log();
    send_byte(8'h44); send_byte(8'h55);
    #1;
    chk("t6_pre_busy", {31'b0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_mw_busy",  {31'b0, busy},  32'h0);
    chk("t6_mw_ready", {31'b0, ready}, 32'h0);
    chk("t6_mw_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset during GAP with a second word still queued
    hold = 1'b1;
    send_word(32'h0000_000A);
    send_word(32'h0000_000B);
    idle(2);
    hold = 1'b0;
    idle(2);
    #2;
    chk("t6_gap_cnt",  q_val.size(), 1);
    chk("t6_gap_val",  val_at(0), 32'h0000_000A);
    chk("t6_gap_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_g_busy",  {31'b0, busy},  32'h0);
    chk("t6_g_ready", {31'b0, ready}, 32'h0);
    chk("t6_g_instr", instr, 32'h0);
    chk("t6_g_ovf",   {31'b0, ovf},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    idle(10);
    chk("t6_quiet", q_val.size(), 0);
    chk("t6_idle_busy", {31'b0, busy}, 32'h0);
    send_word(32'h0607_0809);
    t_last = cyc;
    idle(4);
    chk("t6_count", q_val.size(), 1);
    chk("t6_val",   val_at(0), 32'h0607_0809);
    chk("t6_lat",   cyc_at(0), t_last + 2);

    chk("zero_when_idle", nz_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
